// File: rtl/tl_mo_master.sv
`default_nettype none
// ============================================================================
// Module   : tl_mo_master
// Purpose  : Multiple-outstanding TileLink-UL master. Converts a simple
//            request handshake into A-channel Get/PutFull/PutPartial messages,
//            allocates one source ID per in-flight transaction, and forwards
//            D-channel beats (in any order) to a response handshake.
// Options  : TL_RSP_CHECK_EN - drop and flag D beats that match no busy slot
//            or carry the wrong opcode for the stored transaction type.
// Revision : 1.0 - initial release
// ============================================================================

`ifndef TL_ADDR_BITS
`define TL_ADDR_BITS 32
`endif
`ifndef TL_SIZE_BITS
`define TL_SIZE_BITS 3
`endif
`ifndef TL_DATA_BYTES
`define TL_DATA_BYTES 4
`endif
`ifndef TL_SOURCE_BITS
`define TL_SOURCE_BITS 4
`endif
`ifndef TL_SINK_BITS
`define TL_SINK_BITS 1
`endif

module tl_mo_master #(
  parameter int MAX_OUT = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  // request side
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [1:0]                    req_type,
  input  logic [`TL_ADDR_BITS-1:0]      req_address,
  input  logic [`TL_SIZE_BITS-1:0]      req_size,
  input  logic [`TL_DATA_BYTES*8-1:0]   req_data,
  input  logic [`TL_DATA_BYTES-1:0]     req_mask,
  output logic [`TL_SOURCE_BITS-1:0]    req_source,
  // TileLink A channel
  output logic                          a_valid,
  input  logic                          a_ready,
  output logic [2:0]                    a_opcode,
  output logic [2:0]                    a_param,
  output logic [`TL_SIZE_BITS-1:0]      a_size,
  output logic [`TL_SOURCE_BITS-1:0]    a_source,
  output logic [`TL_ADDR_BITS-1:0]      a_address,
  output logic [`TL_DATA_BYTES-1:0]     a_mask,
  output logic [`TL_DATA_BYTES*8-1:0]   a_data,
  // TileLink D channel
  input  logic                          d_valid,
  output logic                          d_ready,
  input  logic [3:0]                    d_opcode,
  input  logic [1:0]                    d_param,
  input  logic [`TL_SIZE_BITS-1:0]      d_size,
  input  logic [`TL_SOURCE_BITS-1:0]    d_source,
  input  logic [`TL_SINK_BITS-1:0]      d_sink,
  input  logic                          d_denied,
  input  logic [`TL_DATA_BYTES*8-1:0]   d_data,
  // response side
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [`TL_SOURCE_BITS-1:0]    rsp_source,
  output logic [`TL_DATA_BYTES*8-1:0]   rsp_data,
  output logic                          rsp_denied,
  output logic                          rsp_is_data,
  output logic [$clog2(MAX_OUT+1)-1:0]  outstanding_cnt,
  output logic                          rsp_error
);

  localparam int SRC_W = `TL_SOURCE_BITS;
  localparam int CNT_W = $clog2(MAX_OUT+1);
  localparam int MSK_W = `TL_DATA_BYTES;

  localparam logic [1:0] TYPE_PUTFULL = 2'd1;
  localparam logic [1:0] TYPE_PUTPART = 2'd2;

  localparam logic [2:0] OP_GET     = 3'd4;
  localparam logic [2:0] OP_PUTFULL = 3'd0;
  localparam logic [2:0] OP_PUTPART = 3'd1;

  localparam logic [3:0] OP_ACCESSACK     = 4'd0;
  localparam logic [3:0] OP_ACCESSACKDATA = 4'd1;

  // Per-slot tracking state
  logic [MAX_OUT-1:0] busy;
  logic [1:0]         slot_type [MAX_OUT];
  logic [MAX_OUT-1:0] hit;

  logic               any_free;
  logic [SRC_W-1:0]   free_idx;
  logic               alloc;
  logic               d_fire;
  logic               src_busy;
  logic [1:0]         src_type;
  logic [3:0]         exp_opcode;
  logic               beat_ok;
  logic               fwd;
  logic               free_en;

  // One-hot decode of d_source against each slot index
  generate
    for (genvar i = 0; i < MAX_OUT; i++) begin : g_hit
      assign hit[i] = (d_source == SRC_W'(i));
    end
  endgenerate

  // Lowest-index free slot, scanning from the top so the lowest wins
  always_comb begin
    any_free = 1'b0;
    free_idx = '0;
    for (int i = MAX_OUT - 1; i >= 0; i--) begin
      if (!busy[i]) begin
        any_free = 1'b1;
        free_idx = SRC_W'(i);
      end
    end
  end

  // Look up busy/type of the slot addressed by the incoming D beat
  always_comb begin
    src_type = 2'd0;
    for (int i = 0; i < MAX_OUT; i++) begin
      if (hit[i]) src_type = slot_type[i];
    end
  end

  assign src_busy   = |(busy & hit);
  assign exp_opcode = (src_type == TYPE_PUTFULL || src_type == TYPE_PUTPART)
                      ? OP_ACCESSACK : OP_ACCESSACKDATA;
  assign beat_ok    = src_busy && (d_opcode == exp_opcode);

  assign req_source = free_idx;
  assign req_ready  = any_free && (!a_valid || a_ready);
  assign alloc      = req_valid && req_ready;
  assign d_ready    = !rsp_valid || rsp_ready;
  assign d_fire     = d_valid && d_ready;

`ifdef TL_RSP_CHECK_EN
  assign fwd     = d_fire && beat_ok;
  assign free_en = fwd;
`else
  assign fwd     = d_fire;
  assign free_en = d_fire && src_busy;
`endif

  logic unused_inputs;
  assign unused_inputs = ^{d_param, d_size, d_sink, beat_ok};

  // Slot allocation on request acceptance, release on a matching D beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
      for (int i = 0; i < MAX_OUT; i++) slot_type[i] <= 2'd0;
    end else begin
      for (int i = 0; i < MAX_OUT; i++) begin
        if (free_en && hit[i]) busy[i] <= 1'b0;
        if (alloc && free_idx == SRC_W'(i)) begin
          busy[i]      <= 1'b1;
          slot_type[i] <= req_type;
        end
      end
    end
  end

  // A-channel register: loads on acceptance, holds while stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_valid   <= 1'b0;
      a_opcode  <= 3'd0;
      a_param   <= 3'd0;
      a_size    <= '0;
      a_source  <= '0;
      a_address <= '0;
      a_mask    <= '0;
      a_data    <= '0;
    end else if (alloc) begin
      a_valid   <= 1'b1;
      a_param   <= 3'd0;
      a_size    <= req_size;
      a_source  <= free_idx;
      a_address <= req_address;
      a_data    <= req_data;
      case (req_type)
        TYPE_PUTFULL: begin
          a_opcode <= OP_PUTFULL;
          a_mask   <= {MSK_W{1'b1}};
        end
        TYPE_PUTPART: begin
          a_opcode <= OP_PUTPART;
          a_mask   <= req_mask;
        end
        default: begin
          a_opcode <= OP_GET;
          a_mask   <= {MSK_W{1'b1}};
        end
      endcase
    end else if (a_ready) begin
      a_valid <= 1'b0;
    end
  end

  // Response register: captures each forwarded D beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid   <= 1'b0;
      rsp_source  <= '0;
      rsp_data    <= '0;
      rsp_denied  <= 1'b0;
      rsp_is_data <= 1'b0;
    end else if (fwd) begin
      rsp_valid   <= 1'b1;
      rsp_source  <= d_source;
      rsp_data    <= d_data;
      rsp_denied  <= d_denied;
      rsp_is_data <= (d_opcode == OP_ACCESSACKDATA);
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

  // In-flight counter; simultaneous allocate and free cancel out
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outstanding_cnt <= '0;
    end else begin
      case ({alloc, free_en})
        2'b10:   outstanding_cnt <= outstanding_cnt + CNT_W'(1);
        2'b01:   outstanding_cnt <= outstanding_cnt - CNT_W'(1);
        default: outstanding_cnt <= outstanding_cnt;
      endcase
    end
  end

`ifdef TL_RSP_CHECK_EN
  // Sticky flag for D beats that matched no outstanding transaction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_error <= 1'b0;
    end else if (d_fire && !beat_ok) begin
      rsp_error <= 1'b1;
    end
  end
`else
  assign rsp_error = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_tl_mo_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_tl_mo_master
// Purpose  : Self-checking bench for tl_mo_master: directed scenarios with
//            literal expectations followed by randomized traffic compared
//            every cycle against a transaction-level model.
// Revision : 1.0 - initial release
// ============================================================================

`ifndef TL_ADDR_BITS
`define TL_ADDR_BITS 32
`endif
`ifndef TL_SIZE_BITS
`define TL_SIZE_BITS 3
`endif
`ifndef TL_DATA_BYTES
`define TL_DATA_BYTES 4
`endif
`ifndef TL_SOURCE_BITS
`define TL_SOURCE_BITS 4
`endif
`ifndef TL_SINK_BITS
`define TL_SINK_BITS 1
`endif

module tb_tl_mo_master;

  localparam int MAX_OUT = 4;
  localparam int AW = `TL_ADDR_BITS;
  localparam int ZW = `TL_SIZE_BITS;
  localparam int DB = `TL_DATA_BYTES;
  localparam int SW = `TL_SOURCE_BITS;
  localparam int KW = `TL_SINK_BITS;
  localparam int CW = $clog2(MAX_OUT+1);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req_valid = 0, a_ready = 0, d_valid = 0, rsp_ready = 0, d_denied = 0;
  logic [1:0] req_type = 0, d_param = 0;
  logic [AW-1:0] req_address = 0;
  logic [ZW-1:0] req_size = 0, d_size = 0;
  logic [DB*8-1:0] req_data = 0, d_data = 0;
  logic [DB-1:0] req_mask = 0;
  logic [3:0] d_opcode = 0;
  logic [SW-1:0] d_source = 0;
  logic [KW-1:0] d_sink = 0;

  logic req_ready, a_valid, d_ready, rsp_valid, rsp_denied, rsp_is_data, rsp_error;
  logic [SW-1:0] req_source, a_source, rsp_source;
  logic [2:0] a_opcode, a_param;
  logic [ZW-1:0] a_size;
  logic [AW-1:0] a_address;
  logic [DB-1:0] a_mask;
  logic [DB*8-1:0] a_data, rsp_data;
  logic [CW-1:0] outstanding_cnt;

  tl_mo_master #(.MAX_OUT(MAX_OUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_type(req_type),
    .req_address(req_address), .req_size(req_size), .req_data(req_data),
    .req_mask(req_mask), .req_source(req_source),
    .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode), .a_param(a_param),
    .a_size(a_size), .a_source(a_source), .a_address(a_address),
    .a_mask(a_mask), .a_data(a_data),
    .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode), .d_param(d_param),
    .d_size(d_size), .d_source(d_source), .d_sink(d_sink), .d_denied(d_denied),
    .d_data(d_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_source(rsp_source),
    .rsp_data(rsp_data), .rsp_denied(rsp_denied), .rsp_is_data(rsp_is_data),
    .outstanding_cnt(outstanding_cnt), .rsp_error(rsp_error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  bit        m_busy [MAX_OUT];
  bit [1:0]  m_type [MAX_OUT];
  bit        m_aval;
  bit [2:0]  m_a_op;
  bit [ZW-1:0] m_a_size;
  bit [SW-1:0] m_a_src;
  bit [AW-1:0] m_a_addr;
  bit [DB-1:0] m_a_mask;
  bit [DB*8-1:0] m_a_data;
  bit [1:0]  m_a_type;
  bit        m_rval;
  bit [SW-1:0] m_r_src;
  bit [DB*8-1:0] m_r_data;
  bit        m_r_den, m_r_isd;
  bit        m_err;
  bit        req_taken, d_taken;

  typedef struct { bit [SW-1:0] src; bit [1:0] typ; } pend_t;
  pend_t pend [$];

  function automatic int lowest_free();
    for (int i = 0; i < MAX_OUT; i++) if (!m_busy[i]) return i;
    return -1;
  endfunction

  function automatic int busy_count();
    int n = 0;
    for (int i = 0; i < MAX_OUT; i++) if (m_busy[i]) n++;
    return n;
  endfunction

  // Model advances one transaction step on every clock edge
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MAX_OUT; i++) begin m_busy[i] = 0; m_type[i] = 0; end
      m_aval = 0; m_a_op = 0; m_a_size = 0; m_a_src = 0; m_a_addr = 0;
      m_a_mask = 0; m_a_data = 0; m_a_type = 0;
      m_rval = 0; m_r_src = 0; m_r_data = 0; m_r_den = 0; m_r_isd = 0;
      m_err = 0; req_taken = 0; d_taken = 0;
    end else begin
      int f, s;
      bit acc, dfire, sb, ok, fwd, fr;
      f = lowest_free();
      acc = req_valid && (f >= 0) && (!m_aval || a_ready);
      dfire = d_valid && (!m_rval || rsp_ready);
      s = int'(d_source);
      sb = (s < MAX_OUT) && m_busy[s < MAX_OUT ? s : 0];
      ok = sb && (d_opcode == ((m_type[s < MAX_OUT ? s : 0] inside {2'd1, 2'd2}) ? 4'd0 : 4'd1));
`ifdef TL_RSP_CHECK_EN
      fwd = dfire && ok;
      fr  = fwd;
      if (dfire && !ok) m_err = 1;
`else
      fwd = dfire;
      fr  = dfire && sb;
`endif
      if (m_aval && a_ready) pend.push_back('{m_a_src, m_a_type});
      if (acc) begin
        m_aval = 1; m_a_size = req_size; m_a_src = SW'(f); m_a_addr = req_address;
        m_a_data = req_data; m_a_type = req_type;
        m_a_op   = (req_type == 1) ? 3'd0 : (req_type == 2) ? 3'd1 : 3'd4;
        m_a_mask = (req_type == 2) ? req_mask : {DB{1'b1}};
      end else if (a_ready) m_aval = 0;
      if (fwd) begin
        m_rval = 1; m_r_src = d_source; m_r_data = d_data;
        m_r_den = d_denied; m_r_isd = (d_opcode == 4'd1);
      end else if (rsp_ready) m_rval = 0;
      if (fr) m_busy[s] = 0;
      if (acc) begin m_busy[f] = 1; m_type[f] = req_type; end
      req_taken = acc;
      d_taken = dfire;
    end
  end

  // Compare every DUT output against the model each cycle
  always @(negedge clk) begin
    #2;
    begin
      int f;
      f = lowest_free();
      chk("req_ready", req_ready, (f >= 0) && (!m_aval || a_ready));
      if (f >= 0) chk("req_source", req_source, f);
      chk("a_valid", a_valid, m_aval);
      chk("a_opcode", a_opcode, m_a_op);
      chk("a_param", a_param, 0);
      chk("a_size", a_size, m_a_size);
      chk("a_source", a_source, m_a_src);
      chk("a_address", a_address, m_a_addr);
      chk("a_mask", a_mask, m_a_mask);
      chk("a_data", a_data, m_a_data);
      chk("d_ready", d_ready, !m_rval || rsp_ready);
      chk("rsp_valid", rsp_valid, m_rval);
      chk("rsp_source", rsp_source, m_r_src);
      chk("rsp_data", rsp_data, m_r_data);
      chk("rsp_denied", rsp_denied, m_r_den);
      chk("rsp_is_data", rsp_is_data, m_r_isd);
      chk("outstanding_cnt", outstanding_cnt, busy_count());
      chk("rsp_error", rsp_error, m_err);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle();
    req_valid = 0; d_valid = 0; a_ready = 1; rsp_ready = 1;
    req_type = 0; req_address = 0; req_size = 0; req_data = 0; req_mask = 0;
    d_opcode = 0; d_source = 0; d_data = 0; d_denied = 0; d_param = 0; d_size = 0; d_sink = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0;
    idle();
    pend.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic set_req(input logic [1:0] t, input logic [AW-1:0] ad, input logic [DB-1:0] mk);
    req_valid = 1; req_type = t; req_address = ad; req_mask = mk;
    req_size = 2; req_data = ad[DB*8-1:0] ^ 32'h5A5A_0000;
  endtask

  task automatic set_d(input logic [SW-1:0] s, input logic [3:0] op, input logic [DB*8-1:0] dt, input logic den);
    d_valid = 1; d_source = s; d_opcode = op; d_data = dt; d_denied = den;
  endtask

  initial begin
    idle();
    rst_n = 0;
    @(negedge clk);
    @(negedge clk);
    #3;
    chk("rst a_valid", a_valid, 0);
    chk("rst rsp_valid", rsp_valid, 0);
    chk("rst cnt", outstanding_cnt, 0);
    chk("rst rsp_error", rsp_error, 0);
    chk("rst a_address", a_address, 0);
    @(negedge clk);
    rst_n = 1;
    #3 chk("first req_ready", req_ready, 1);

    // Get to 0x100 and its AccessAckData
    set_req(2'd0, 32'h100, 4'h0);
    @(negedge clk); req_valid = 0;
    #3;
    chk("get a_valid", a_valid, 1);
    chk("get a_opcode", a_opcode, 4);
    chk("get a_source", a_source, 0);
    chk("get a_mask", a_mask, 4'hF);
    set_d(0, 4'd1, 32'hDEADBEEF, 0);
    @(negedge clk); d_valid = 0;
    #3;
    chk("get rsp_data", rsp_data, 32'hDEADBEEF);
    chk("get rsp_is_data", rsp_is_data, 1);
    chk("get cnt", outstanding_cnt, 0);

    // Four PutFulls fill every slot, then source 2 is recycled
    do_reset();
    for (int k = 0; k < 4; k++) begin
      if (k != 0) @(negedge clk);
      set_req(2'd1, AW'(k * 16), 4'h0);
      #3 chk("fill req_source", req_source, k);
    end
    @(negedge clk); req_valid = 0;
    #3;
    chk("full req_ready", req_ready, 0);
    chk("full cnt", outstanding_cnt, 4);
    set_d(2, 4'd0, 0, 0);
    @(negedge clk); d_valid = 0;
    #3;
    chk("recycle req_source", req_source, 2);
    chk("recycle req_ready", req_ready, 1);
    chk("recycle cnt", outstanding_cnt, 3);

    // Out-of-order completion 3,0,2,1
    set_req(2'd1, 32'h40, 4'h0);
    @(negedge clk); req_valid = 0; set_d(3, 4'd0, 3, 0);
    @(negedge clk); set_d(0, 4'd0, 0, 0);
    #3 chk("ooo rsp 3", rsp_source, 3);
    @(negedge clk); set_d(2, 4'd0, 2, 0);
    #3 chk("ooo rsp 0", rsp_source, 0);
    @(negedge clk); set_d(1, 4'd0, 1, 0);
    #3 chk("ooo rsp 2", rsp_source, 2);
    @(negedge clk); d_valid = 0;
    #3;
    chk("ooo rsp 1", rsp_source, 1);
    chk("ooo cnt", outstanding_cnt, 0);

    // A-channel stall holds the payload
    do_reset();
    a_ready = 0;
    set_req(2'd0, 32'h200, 4'h0);
    @(negedge clk); set_req(2'd1, 32'h300, 4'h0);
    for (int k = 0; k < 5; k++) begin
      #3;
      chk("stall a_valid", a_valid, 1);
      chk("stall a_address", a_address, 32'h200);
      chk("stall a_opcode", a_opcode, 4);
      chk("stall req_ready", req_ready, 0);
      @(negedge clk);
    end
    req_valid = 0; a_ready = 1;

    // PutPartial with denied response
    do_reset();
    set_req(2'd2, 32'h80, 4'h3);
    @(negedge clk); req_valid = 0;
    #3;
    chk("pp a_opcode", a_opcode, 1);
    chk("pp a_mask", a_mask, 4'h3);
    set_d(0, 4'd0, 0, 1);
    @(negedge clk); d_valid = 0;
    #3;
    chk("pp rsp_denied", rsp_denied, 1);
    chk("pp rsp_is_data", rsp_is_data, 0);

    // Beat for a source that is not outstanding
    do_reset();
    set_d(1, 4'd0, 32'h1234, 0);
    @(negedge clk); d_valid = 0;
    #3;
`ifdef TL_RSP_CHECK_EN
    chk("stray rsp_valid", rsp_valid, 0);
    chk("stray rsp_error", rsp_error, 1);
`else
    chk("stray rsp_valid", rsp_valid, 1);
    chk("stray rsp_source", rsp_source, 1);
    chk("stray rsp_error", rsp_error, 0);
`endif

    // Randomized traffic with a mid-run reset
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      if (cyc == 1500) begin
        rst_n = 0; idle(); pend.delete();
        continue;
      end
      if (cyc == 1502) rst_n = 1;
      if (!rst_n) continue;
      a_ready   = ($urandom_range(0, 3) != 0);
      rsp_ready = ($urandom_range(0, 3) != 0);
      if (!req_valid || req_taken) begin
        req_valid = ($urandom_range(0, 2) != 0);
        req_type = 2'($urandom_range(0, 3));
        req_address = $urandom;
        req_size = ZW'($urandom_range(0, 2));
        req_data = $urandom;
        req_mask = DB'($urandom);
      end
      if (!d_valid || d_taken) begin
        d_valid = 0;
        d_sink = KW'($urandom);
        d_size = ZW'($urandom_range(0, 2));
        d_param = 0;
        if (pend.size() > 0 && $urandom_range(0, 2) != 0) begin
          int idx;
          pend_t e;
          idx = $urandom_range(0, pend.size() - 1);
          e = pend[idx];
          pend.delete(idx);
          set_d(e.src, (e.typ inside {2'd1, 2'd2}) ? 4'd0 : 4'd1, $urandom,
                1'($urandom_range(0, 7) == 0));
        end else if ($urandom_range(0, 15) == 0) begin
          int s;
          s = $urandom_range(0, MAX_OUT - 1);
          if (!m_busy[s]) set_d(SW'(s), 4'($urandom_range(0, 1)), $urandom, 0);
        end
      end
    end
    @(negedge clk);
    idle();
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
